ring_local_rx: RTL and testbench
================================

RING_LOCAL_RX -- requirements
Module: ring_local_rx

Interface
REQ-001 Parameter MAX_PAYLOAD, default 4, maximum payload flits per packet (1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id  input  10  local node address; compared against bits [9:0] of the first flit.
REQ-005 in_flit  input  dii_flit (valid, last, data[15:0])  flit stream from the router local output port.
REQ-006 in_ready  output  1  flit accepted on a cycle where in_flit.valid && in_ready.
REQ-007 pkt_valid  output  1  a complete packet is held on the pkt_* outputs.
REQ-008 pkt_ready  input  1  consumer takes the packet on a cycle where pkt_valid && pkt_ready.
REQ-009 pkt_dest, pkt_src, pkt_flags  output  16 each  header flits 0, 1 and 2.
REQ-010 pkt_len  output  4  number of payload flits captured (0..MAX_PAYLOAD).
REQ-011 pkt_data  output  16*MAX_PAYLOAD  payload; flit k is in bits [16k+15:16k]; unused words are 0.
REQ-012 drop_count  output  8  saturating count of discarded packets.

Function
REQ-013 States: DEST, SRC, FLAGS, PAYLOAD, DRAIN, HOLD.
REQ-014 in_ready is 1 in every state except HOLD.
REQ-015 DEST: on an accepted flit, capture pkt_dest.
- data[9:0]==id and !last -> SRC.
- data[9:0]!=id and !last -> DRAIN.
- last -> drop, stay in DEST.
REQ-016 SRC: on an accepted flit, capture pkt_src.
- !last -> FLAGS.
- last -> drop, go to DEST.
REQ-017 FLAGS: on an accepted flit, capture pkt_flags and clear pkt_len and pkt_data.
- last -> HOLD with pkt_len=0.
- !last -> PAYLOAD.
REQ-018 PAYLOAD: on an accepted flit, write data to word pkt_len and increment pkt_len.
- last -> HOLD.
- If pkt_len reaches MAX_PAYLOAD without last -> DRAIN.
REQ-019 DRAIN: accept and discard flits until a flit with last is accepted, then drop and go to DEST.
REQ-020 A drop increments drop_count by 1, saturating at 255; at most one increment per packet.
REQ-021 HOLD: pkt_valid=1 and all pkt_* outputs stay stable until pkt_ready; on pkt_ready go to DEST.
REQ-022 pkt_valid is 1 only in HOLD; it rises in the cycle after the last flit is accepted.
REQ-023 Backpressure between packets: the cycle in which pkt_ready is sampled still has in_ready=0; the next flit is accepted one cycle later at the earliest.
REQ-024 Throughput: one flit per cycle in DEST, SRC, FLAGS, PAYLOAD and DRAIN.
REQ-025 A cycle with in_flit.valid=0 changes no state.
REQ-026 id may change only while in DEST.
REQ-027 pkt_ready is ignored outside HOLD.

Reset
REQ-028 Asserting rst at any time forces the following immediately:
- state DEST, pkt_valid=0, in_ready=1;
- pkt_dest, pkt_src, pkt_flags, pkt_len, pkt_data and drop_count all 0.
REQ-029 A packet in progress when rst asserts is lost and is not counted as a drop.
REQ-030 After rst deasserts, the first accepted flit is treated as a destination flit.

Verification
REQ-031 Bench with id=0x005, MAX_PAYLOAD=4 shall cover:
- Valid packet: flits 0x0005,0x0003,0x1000,0xAAAA,0xBBBB(last), pkt_ready=1 -> pkt_valid one cycle after the last flit; pkt_len=2, pkt_data word0=0xAAAA, word1=0xBBBB, words 2-3=0.
- Wrong destination: flits 0x0006,0x0003,0x1000(last) -> no pkt_valid; drop_count=1; the next valid packet is received normally.
- Oversize packet: destination 0x0005 with 6 payload flits -> no pkt_valid; drop_count=1; all flits accepted with in_ready=1.
- Backpressure: hold pkt_ready=0 for 10 cycles after a valid packet -> in_ready=0, outputs stable; with back-to-back packets, the second packet is accepted only after pkt_ready.
- Header-only and truncated packets:
  - 3-flit packet -> pkt_len=0, pkt_valid=1.
  - 2-flit packet -> drop_count increments, no pkt_valid.
- Reset: rst asserted mid-PAYLOAD and in HOLD -> all outputs 0 at once; drop_count saturates at 255 after 300 wrong-destination packets.

Source files
------------

// File: rtl/ring_local_rx_if.sv
// Local-port receive bundle: router flit stream in, assembled packet out.
// Latency: n/a (signal grouping only).
// Backpressure: in_ready throttles flits; pkt_ready releases the held packet.
interface ring_local_rx_if #(
  parameter int MAX_PAYLOAD = 4
);
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit_t;

  dii_flit_t                 in_flit;
  logic                      in_ready;
  logic                      pkt_valid;
  logic                      pkt_ready;
  logic [15:0]               pkt_dest;
  logic [15:0]               pkt_src;
  logic [15:0]               pkt_flags;
  logic [3:0]                pkt_len;
  logic [16*MAX_PAYLOAD-1:0] pkt_data;

  // The receiver drives the packet side and consumes flits.
  modport master (
    input  in_flit, pkt_ready,
    output in_ready, pkt_valid, pkt_dest, pkt_src, pkt_flags, pkt_len, pkt_data
  );

  // The surrounding logic: flit source and packet consumer.
  modport slave (
    output in_flit, pkt_ready,
    input  in_ready, pkt_valid, pkt_dest, pkt_src, pkt_flags, pkt_len, pkt_data
  );
endinterface

// File: rtl/ring_local_rx.sv
// Assembles dest/src/flags/payload flits addressed to this node into one packet.
// Latency: pkt_valid rises the cycle after the last flit is accepted.
// Backpressure: in_ready=0 while a packet is held; flits resume the cycle after pkt_ready.
module ring_local_rx #(
  parameter int MAX_PAYLOAD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      id,
  ring_local_rx_if.master rx,
  output logic [7:0]      drop_count
);

  typedef enum logic [2:0] {
    DEST,
    SRC,
    FLAGS,
    PAYLOAD,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_PAYLOAD);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        drop;
  logic        flit_last;
  logic [15:0] flit_data;

  assign flit_last    = rx.in_flit.last;
  assign flit_data    = rx.in_flit.data;
  assign rx.in_ready  = (state != HOLD);
  assign rx.pkt_valid = (state == HOLD);
  assign accept       = rx.in_flit.valid && rx.in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; drop pulses once, on the flit that ends a discarded packet.
  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    if (accept) begin
      case (state)
        DEST: begin
          if (flit_last) begin
            drop = 1'b1;
          end else if (flit_data[9:0] == id) begin
            state_nxt = SRC;
          end else begin
            state_nxt = DRAIN;
          end
        end
        SRC: begin
          if (flit_last) begin
            drop      = 1'b1;
            state_nxt = DEST;
          end else begin
            state_nxt = FLAGS;
          end
        end
        FLAGS: begin
          state_nxt = flit_last ? HOLD : PAYLOAD;
        end
        PAYLOAD: begin
          if (flit_last) begin
            state_nxt = HOLD;
          end else if (rx.pkt_len + 4'd1 == MAX_LEN) begin
            // Buffer full and the packet keeps going: discard the remainder.
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (flit_last) begin
            drop      = 1'b1;
            state_nxt = DEST;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
    // pkt_ready only matters while a packet is presented.
    if (state == HOLD && rx.pkt_ready) begin
      state_nxt = DEST;
    end
  end

  // Packet field capture; nothing moves while HOLD since no flit is accepted there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx.pkt_dest  <= '0;
      rx.pkt_src   <= '0;
      rx.pkt_flags <= '0;
      rx.pkt_len   <= '0;
      rx.pkt_data  <= '0;
    end else if (accept) begin
      case (state)
        DEST: begin
          rx.pkt_dest <= flit_data;
        end
        SRC: begin
          rx.pkt_src <= flit_data;
        end
        FLAGS: begin
          rx.pkt_flags <= flit_data;
          rx.pkt_len   <= '0;
          rx.pkt_data  <= '0;
        end
        PAYLOAD: begin
          for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (rx.pkt_len == 4'(k)) begin
              rx.pkt_data[16*k +: 16] <= flit_data;
            end
          end
          rx.pkt_len <= rx.pkt_len + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating discard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ring_local_rx.sv
// Directed + randomized bench for ring_local_rx against a packet-level model.
// Latency: checks pkt_valid the cycle after the last flit.
// Backpressure: holds pkt_ready low with the next flit waiting and checks it is not taken.
module tb_ring_local_rx;
  localparam int         MP = 4;
  localparam logic [9:0] ID = 10'h005;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] id;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;

  ring_local_rx_if #(.MAX_PAYLOAD(MP)) rx ();

  ring_local_rx #(.MAX_PAYLOAD(MP)) dut (
    .clk        (clk),
    .rst        (rst),
    .id         (id),
    .rx         (rx),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packet-level reference: a packet is delivered iff it has the three header
  // flits, is addressed to us, and its payload fits; otherwise it is one drop.
  function automatic bit model_accepts(input logic [15:0] f[$]);
    logic [15:0] d;
    if (f.size() < 3) return 1'b0;
    d = f[0];
    if (d[9:0] != ID) return 1'b0;
    return (f.size() - 3) <= MP;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  64'(rx.in_ready),  64'd1);
    chk({tag, "_pkt_valid"}, 64'(rx.pkt_valid), 64'd0);
    chk({tag, "_dest"},      64'(rx.pkt_dest),  64'd0);
    chk({tag, "_src"},       64'(rx.pkt_src),   64'd0);
    chk({tag, "_flags"},     64'(rx.pkt_flags), 64'd0);
    chk({tag, "_len"},       64'(rx.pkt_len),   64'd0);
    chk({tag, "_data"},      64'(rx.pkt_data),  64'd0);
    chk({tag, "_drops"},     64'(drop_count),   64'd0);
  endtask

  // Drives the flits with random idle cycles (valid=0, junk data) and random
  // pkt_ready, which must be ignored outside HOLD.
  task automatic send_pkt(input logic [15:0] f[$], input bit end_last);
    for (int i = 0; i < f.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx.in_flit.valid = 1'b0;
        rx.in_flit.data  = 16'($urandom);
        rx.in_flit.last  = 1'($urandom);
        rx.pkt_ready     = 1'($urandom);
        @(posedge clk);
        #1;
      end
      rx.in_flit.valid = 1'b1;
      rx.in_flit.data  = f[i];
      rx.in_flit.last  = end_last && (i == f.size() - 1);
      rx.pkt_ready     = 1'($urandom);
      chk("flit_in_ready", 64'(rx.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    rx.in_flit.valid = 1'b0;
    rx.in_flit.last  = 1'b0;
  endtask

  // Called #1 after the edge that took the last flit.
  task automatic expect_outcome(input logic [15:0] f[$], input int hold_cycles,
                                input bit present_next, input logic [15:0] next_first);
    logic [63:0] exp_data;
    logic [3:0]  exp_len;
    rx.pkt_ready = 1'b0;
    if (model_accepts(f)) begin
      exp_len  = 4'(f.size() - 3);
      exp_data = '0;
      for (int i = 0; i < f.size() - 3; i++) exp_data[16*i +: 16] = f[3+i];
      if (present_next) begin
        rx.in_flit.valid = 1'b1;
        rx.in_flit.data  = next_first;
        rx.in_flit.last  = 1'b0;
      end
      for (int c = 0; c <= hold_cycles; c++) begin
        chk("pkt_valid", 64'(rx.pkt_valid), 64'd1);
        chk("hold_in_ready", 64'(rx.in_ready), 64'd0);
        chk("pkt_dest", 64'(rx.pkt_dest), 64'(f[0]));
        chk("pkt_src", 64'(rx.pkt_src), 64'(f[1]));
        chk("pkt_flags", 64'(rx.pkt_flags), 64'(f[2]));
        chk("pkt_len", 64'(exp_len), 64'(rx.pkt_len));
        chk("pkt_data", rx.pkt_data, exp_data);
        if (c < hold_cycles) begin
          @(posedge clk);
          #1;
        end
      end
      rx.pkt_ready = 1'b1;
      @(posedge clk);
      #1;
      rx.pkt_ready = 1'b0;
      chk("released_valid", 64'(rx.pkt_valid), 64'd0);
      chk("released_in_ready", 64'(rx.in_ready), 64'd1);
    end else begin
      exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      chk("dropped_no_valid", 64'(rx.pkt_valid), 64'd0);
    end
    chk("drop_count", 64'(drop_count), 64'(exp_drops));
  endtask

  task automatic run_pkt(input logic [15:0] f[$], input int hold_cycles);
    send_pkt(f, 1'b1);
    expect_outcome(f, hold_cycles, 1'b0, 16'h0);
  endtask

  function automatic logic [15:0] wrong_dest();
    logic [15:0] d;
    d = 16'($urandom);
    if (d[9:0] == ID) d = d ^ 16'h0001;
    return d;
  endfunction

  initial begin
    logic [15:0] q[$];
    logic [15:0] q2[$];

    rst = 1'b1;
    id  = ID;
    rx.in_flit   = '0;
    rx.pkt_ready = 1'b0;
    #1;
    check_reset_state("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic valid packet with two payload flits.
    q = '{16'h0005, 16'h0003, 16'h1000, 16'hAAAA, 16'hBBBB};
    run_pkt(q, 0);

    // Wrong destination, then a normal packet.
    q = '{16'h0006, 16'h0003, 16'h1000};
    run_pkt(q, 0);
    q = '{16'h0005, 16'h0007, 16'h2000, 16'h1234};
    run_pkt(q, 2);

    // Oversize: six payload flits.
    q = '{16'h0005, 16'h0003, 16'h1000, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
    run_pkt(q, 0);

    // Exactly MAX_PAYLOAD payload flits still fits.
    q = '{16'h0005, 16'h0011, 16'h0022, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    run_pkt(q, 1);

    // Backpressure with the next packet's first flit waiting.
    q  = '{16'h0005, 16'h0101, 16'h0202, 16'h0303};
    q2 = '{16'h0005, 16'h0404, 16'h0505, 16'h0606, 16'h0707};
    send_pkt(q, 1'b1);
    expect_outcome(q, 10, 1'b1, q2[0]);
    send_pkt(q2, 1'b1);
    expect_outcome(q2, 0, 1'b0, 16'h0);

    // Header-only and truncated.
    q = '{16'h0005, 16'h0003, 16'h1000};
    run_pkt(q, 0);
    q = '{16'h0005, 16'h0003};
    run_pkt(q, 0);
    q = '{16'h0005};
    run_pkt(q, 0);

    // Randomized packets.
    for (int n = 0; n < 60; n++) begin
      int len;
      len = $urandom_range(1, 9);
      q.delete();
      q.push_back(($urandom_range(0, 3) != 0) ? {6'($urandom), ID} : wrong_dest());
      for (int i = 1; i < len; i++) q.push_back(16'($urandom));
      run_pkt(q, $urandom_range(0, 3));
    end

    // Reset mid-payload: everything clears at once, nothing counted as a drop.
    q = '{16'h0005, 16'h0003, 16'h1000, 16'hAAAA};
    send_pkt(q, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_state("rst_payload");
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q = '{16'h0005, 16'h0033, 16'h0044, 16'h0055};
    run_pkt(q, 0);

    // Reset while a packet is held.
    q = '{16'h0005, 16'h0003, 16'h1000, 16'hCAFE};
    send_pkt(q, 1'b1);
    rx.pkt_ready = 1'b0;
    chk("pre_rst_hold_valid", 64'(rx.pkt_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_state("rst_hold");
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation of the drop counter.
    for (int n = 0; n < 300; n++) begin
      int len;
      len = $urandom_range(1, 4);
      q.delete();
      q.push_back(wrong_dest());
      for (int i = 1; i < len; i++) q.push_back(16'($urandom));
      run_pkt(q, 0);
    end
    chk("drop_saturated", 64'(drop_count), 64'd255);

    // Still receives normally once saturated.
    q = '{16'h0005, 16'h0003, 16'h1000, 16'hAAAA, 16'hBBBB};
    run_pkt(q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
